// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Program-counter owner and instruction fetch front end. Issues
//             one memory request per cycle and queues PC-tagged instructions
//             for decode behind a valid/ready handshake.
//  Revision : 1.0
// ============================================================================
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter int              STEP         = 4,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err,
    output logic [XLEN-1:0] pc_out
);

    localparam int                  c_ALIGN_BITS = $clog2(STEP);
    localparam int                  c_PTR_W      = $clog2(DEPTH);
    localparam int                  c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH      = c_CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]     c_STEP       = XLEN'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [XLEN-1:0]      pc_q,       pc_d;
    logic [XLEN-1:0]      req_pc_q,   req_pc_d;
    logic                 inflight_q, inflight_d;
    logic [c_PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [c_CNT_W-1:0]   count_q,    count_d;
    logic                 misalign_q, misalign_d;

    logic [XLEN-1:0]      data_mem [DEPTH];
    logic [XLEN-1:0]      tag_mem  [DEPTH];

    logic                 w_misaligned;
    logic                 w_redirect;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic [c_CNT_W-1:0]   w_used;

    generate
        if (c_ALIGN_BITS > 0) begin : g_align_chk
            assign w_misaligned = |redirect_pc[c_ALIGN_BITS-1:0];
        end else begin : g_no_align_chk
            assign w_misaligned = 1'b0;
        end
    endgenerate

    // Credits cover queued entries plus the one response that may still land,
    // so a push can never find the queue full.
    assign w_used     = count_q + {{(c_CNT_W-1){1'b0}}, inflight_q};
    assign w_redirect = redirect_valid && (state_q != ST_HALT);
    assign w_issue    = (state_q == ST_FETCH) && enable && !redirect_valid
                        && (w_used < c_DEPTH);
    assign w_push     = inflight_q && !redirect_valid && (state_q == ST_FETCH);
    assign w_pop      = inst_valid && inst_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = w_issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        misalign_d = misalign_q;

        if (state_q == ST_IDLE) begin
            state_d = ST_FETCH;
        end

        if (w_issue) begin
            req_pc_d = pc_q;
        end

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Redirect overrides every queue update made above.
        if (w_redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (w_misaligned) begin
                state_d    = ST_HALT;
                misalign_d = 1'b1;
            end else begin
                pc_d = redirect_pc;
            end
        end else if (w_issue) begin
            pc_d = pc_q + c_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            data_mem[wr_ptr_q] <= imem_rdata;
            tag_mem[wr_ptr_q]  <= req_pc_q;
        end
    end

    assign imem_req     = w_issue;
    assign imem_addr    = w_issue ? pc_q : '0;
    assign inst_valid   = (count_q != '0);
    assign inst_data    = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc      = inst_valid ? tag_mem[rd_ptr_q] : '0;
    assign misalign_err = misalign_q;
    assign pc_out       = pc_q;

    property p_no_overflow;
        @(posedge clk) disable iff (reset)
            !(w_push && !w_pop && (count_q == c_DEPTH));
    endproperty
    a_no_overflow: assert property (p_no_overflow);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Purpose  : Directed self-checking bench for pc_fetch_unit.
//  Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misalign_err;
    logic [31:0] pc_out;

    logic        wr_enable         = 1'b1;
    logic        wr_redirect_valid = 1'b0;
    logic [31:0] wr_redirect_pc    = '0;
    logic        wr_ready          = 1'b1;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_rdata = '0;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic        wr_misalign;
    logic [31:0] wr_pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_addr ^ c_K;
    always @(posedge clk) wr_rdata   <= wr_addr ^ c_K;

    pc_fetch_unit #(
        .XLEN(32), .STEP(4), .DEPTH(4), .RESET_VECTOR(32'h0000_0100)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .misalign_err(misalign_err), .pc_out(pc_out)
    );

    pc_fetch_unit #(
        .XLEN(32), .STEP(4), .DEPTH(4), .RESET_VECTOR(32'hFFFF_FFF8)
    ) u_wrap (
        .clk(clk), .reset(reset), .enable(wr_enable),
        .redirect_valid(wr_redirect_valid), .redirect_pc(wr_redirect_pc),
        .imem_req(wr_req), .imem_addr(wr_addr), .imem_rdata(wr_rdata),
        .inst_valid(wr_valid), .inst_ready(wr_ready),
        .inst_data(wr_data), .inst_pc(wr_pc),
        .misalign_err(wr_misalign), .pc_out(wr_pc_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held across one edge, released just after it.
    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] exp;
        reset          = 1'b1;
        enable         = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;

        // ---------------- reset values and free run ----------------
        step();
        step();
        check_eq("rst_req",      imem_req,     0);
        check_eq("rst_valid",    inst_valid,   0);
        check_eq("rst_misalign", misalign_err, 0);
        check_eq("rst_pc_out",   pc_out,       32'h100);
        check_eq("rst_inst_pc",  inst_pc,      0);
        check_eq("rst_data",     inst_data,    0);
        check_eq("rst_addr",     imem_addr,    0);
        check_eq("rst_wrap_pc",  wr_pc_out,    32'hFFFF_FFF8);
        reset = 1'b0;
        #1;
        check_eq("idle_req", imem_req, 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = 32'h100 + 32'(4 * (i - 1));
            check_eq("run_req",  imem_req,  1);
            check_eq("run_addr", imem_addr, exp);
            if (i < 3) begin
                check_eq("run_valid_early", inst_valid, 0);
            end else begin
                exp = 32'h100 + 32'(4 * (i - 3));
                check_eq("run_valid", inst_valid, 1);
                check_eq("run_pc",    inst_pc,    exp);
                check_eq("run_data",  inst_data,  exp ^ c_K);
                if (i <= 6) begin
                    exp = 32'hFFFF_FFF8 + 32'(4 * (i - 3));
                    check_eq("wrap_pc", wr_pc, exp);
                end
            end
        end

        // ---------------- backpressure fills the queue ----------------
        inst_ready = 1'b0;
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("bp_req",  imem_req,  1);
            check_eq("bp_addr", imem_addr, 32'h100 + 32'(4 * (i - 1)));
        end
        step();
        check_eq("bp_stop_req", imem_req, 0);
        check_eq("bp_pc_out",   pc_out,   32'h110);
        step();
        check_eq("bp_full_req", imem_req,   0);
        check_eq("bp_full_val", inst_valid, 1);
        check_eq("bp_head0",    inst_pc,    32'h100);
        inst_ready = 1'b1;
        step();
        check_eq("bp_head1",   inst_pc,   32'h104);
        check_eq("bp_resume",  imem_req,  1);
        check_eq("bp_res_adr", imem_addr, 32'h110);
        step();
        check_eq("bp_head2", inst_pc, 32'h108);
        step();
        check_eq("bp_head3", inst_pc, 32'h10C);
        step();
        check_eq("bp_head4",  inst_pc,   32'h110);
        check_eq("bp_data4",  inst_data, 32'h110 ^ c_K);

        // ---------------- aligned redirect with full pipeline ----------------
        inst_ready = 1'b0;
        pulse_reset();
        repeat (5) step();
        check_eq("rd_pre_head", inst_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2000;
        inst_ready     = 1'b1;
        #1;
        check_eq("rd_cyc_req", imem_req, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("rd_flush_val", inst_valid, 0);
        check_eq("rd_pc_out",    pc_out,     32'h2000);
        check_eq("rd_new_req",   imem_req,   1);
        check_eq("rd_new_addr",  imem_addr,  32'h2000);
        step();
        check_eq("rd_no_stale", inst_valid, 0);
        step();
        check_eq("rd_tgt_val",  inst_valid, 1);
        check_eq("rd_tgt_pc",   inst_pc,    32'h2000);
        check_eq("rd_tgt_data", inst_data,  32'h2000 ^ c_K);
        step();
        check_eq("rd_next_pc", inst_pc, 32'h2004);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #1;
        check_eq("rd2_cyc_req", imem_req, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("rd2_addr",  imem_addr,  32'h3000);
        check_eq("rd2_val0",  inst_valid, 0);
        step();
        check_eq("rd2_val1", inst_valid, 0);
        step();
        check_eq("rd2_pc", inst_pc, 32'h3000);

        // ---------------- misaligned redirect halts ----------------
        pulse_reset();
        repeat (3) step();
        check_eq("ma_pre_pc", pc_out, 32'h108);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        step();
        redirect_valid = 1'b0;
        #1;
        check_eq("ma_err",   misalign_err, 1);
        check_eq("ma_valid", inst_valid,   0);
        check_eq("ma_pc",    pc_out,       32'h108);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 5);
            redirect_pc    = 32'h4000;
            step();
            check_eq("ma_halt_req", imem_req,     0);
            check_eq("ma_sticky",   misalign_err, 1);
        end
        redirect_valid = 1'b0;
        check_eq("ma_pc_hold", pc_out, 32'h108);
        reset = 1'b1;
        #1;
        check_eq("ma_rst_clr", misalign_err, 0);
        step();
        reset = 1'b0;

        // ---------------- asynchronous reset mid-run ----------------
        inst_ready = 1'b0;
        step();
        step();
        check_eq("ar_req_before", imem_req, 1);
        reset = 1'b1;
        #1;
        check_eq("ar_req_async", imem_req, 0);
        check_eq("ar_pc_async",  pc_out,   32'h100);
        step();
        reset = 1'b0;
        repeat (6) step();
        check_eq("ar_full_val", inst_valid, 1);
        reset = 1'b1;
        #1;
        check_eq("ar_val_async", inst_valid, 0);
        check_eq("ar_req_full",  imem_req,   0);
        check_eq("ar_pc_zero",   inst_pc,    0);
        step();
        step();
        inst_ready = 1'b1;
        reset      = 1'b0;
        step();
        check_eq("ar_restart", imem_addr, 32'h100);
        step();
        check_eq("ar_no_stale", inst_valid, 0);
        step();
        check_eq("ar_first_pc",   inst_pc,   32'h100);
        check_eq("ar_first_data", inst_data, 32'h100 ^ c_K);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
